// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Sequences CPU byte/halfword/word loads and stores onto a single-ported,
// word-organised data memory. Sub-word stores use a read-modify-write pair of
// memory cycles. All outputs come straight from flops, so an asynchronous
// reset removes every memory control immediately.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req                 access request, held high by the CPU until done
//   is_store            1 = store, 0 = load
//   size                00 byte, 01 halfword, 10 word, 11 illegal
//   sign_ext            sign-extend sub-word loads
//   addr, wdata         byte address, right-aligned store data
//   rdata               right-aligned load result (held between loads)
//   done, err           one-cycle completion pulse, error flag valid with done
//   busy                high whenever the unit is not idle
//   cs_ram, we, oe      data memory controls
//   d_addr, d_in        word-aligned memory address, memory write data
//   d_out               combinational memory read data, little-endian
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int instruction_width = 32,
    parameter int ram_depth         = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req,
    input  logic                         is_store,
    input  logic [1:0]                   size,
    input  logic                         sign_ext,
    input  logic [instruction_width-1:0] addr,
    input  logic [instruction_width-1:0] wdata,
    output logic [instruction_width-1:0] rdata,
    output logic                         done,
    output logic                         err,
    output logic                         busy,
    output logic                         cs_ram,
    output logic                         we,
    output logic                         oe,
    output logic [instruction_width-1:0] d_addr,
    output logic [instruction_width-1:0] d_in,
    input  logic [instruction_width-1:0] d_out
);
    localparam int W = instruction_width;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SWR    = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [1:0]     size_q, size_d;
    logic           store_q, store_d, sext_q, sext_d;
    logic [W-1:0]   rdata_q, rdata_d, d_addr_q, d_addr_d, d_in_q, d_in_d;
    logic           done_q, done_d, err_q, err_d, busy_q, busy_d;
    logic           cs_q, cs_d, we_q, we_d, oe_q, oe_d;
    logic           bad_s;

    // Pick the addressed lane out of a memory word and extend it to W bits.
    function automatic logic [W-1:0] load_extend(input logic [W-1:0] word,
                                                 input logic [1:0]   lane,
                                                 input logic [1:0]   sz,
                                                 input logic         sx);
        logic [7:0]   byte_v;
        logic [15:0]  half_v;
        logic [W-1:0] res_v;
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   res_v = {{(W-8){sx & byte_v[7]}}, byte_v};
            2'b01:   res_v = {{(W-16){sx & half_v[15]}}, half_v};
            default: res_v = word;
        endcase
        return res_v;
    endfunction

    // Replace only the addressed lane of a memory word with store data.
    function automatic logic [W-1:0] store_merge(input logic [W-1:0] word,
                                                 input logic [1:0]   lane,
                                                 input logic [1:0]   sz,
                                                 input logic [W-1:0] wd);
        logic [W-1:0] res_v;
        case (sz)
            2'b00: begin
                case (lane)
                    2'd0:    res_v = {word[31:8], wd[7:0]};
                    2'd1:    res_v = {word[31:16], wd[7:0], word[7:0]};
                    2'd2:    res_v = {word[31:24], wd[7:0], word[15:0]};
                    default: res_v = {wd[7:0], word[23:0]};
                endcase
            end
            2'b01:   res_v = lane[1] ? {wd[15:0], word[15:0]} : {word[31:16], wd[15:0]};
            default: res_v = wd;
        endcase
        return res_v;
    endfunction

    // Misaligned, illegal-size or out-of-range request.
    always_comb begin
        bad_s = (size == 2'b11)
             || ((size == 2'b01) && addr[0])
             || ((size == 2'b10) && (addr[1:0] != 2'b00))
             || (addr >= W'(ram_depth));
    end

    // Next state, request latching, and next values of every registered output.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        store_d  = store_q;
        sext_d   = sext_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        cs_d     = 1'b0;
        we_d     = 1'b0;
        oe_d     = 1'b0;
        d_addr_d = '0;
        d_in_d   = '0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    size_d  = size;
                    store_d = is_store;
                    sext_d  = sign_ext;
                    if (bad_s) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else if (!is_store) begin
                        state_d = LOAD;
                    end else if (size == 2'b10) begin
                        state_d = SWR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                rdata_d = load_extend(d_out, addr_q[1:0], size_q, sext_q);
                state_d = RESP;
            end
            SWR:     state_d = RESP;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the state being entered so they leave flops.
        case (state_d)
            LOAD, RMW_RD: begin
                cs_d     = 1'b1;
                oe_d     = 1'b1;
                d_addr_d = {addr_d[W-1:2], 2'b00};
            end
            SWR: begin
                cs_d     = 1'b1;
                we_d     = 1'b1;
                d_addr_d = {addr_d[W-1:2], 2'b00};
                d_in_d   = wdata_d;
            end
            RMW_WR: begin
                // Only reachable from RMW_RD, so d_out is the word being read now.
                cs_d     = 1'b1;
                we_d     = 1'b1;
                d_addr_d = {addr_d[W-1:2], 2'b00};
                d_in_d   = store_merge(d_out, addr_q[1:0], size_q, wdata_q);
            end
            default: begin
                cs_d = 1'b0;
            end
        endcase

        done_d = (state_d == RESP);
        busy_d = (state_d != IDLE);
    end

    // State, latched request and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= 2'b00;
            store_q  <= 1'b0;
            sext_q   <= 1'b0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            cs_q     <= 1'b0;
            we_q     <= 1'b0;
            oe_q     <= 1'b0;
            d_addr_q <= '0;
            d_in_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            store_q  <= store_d;
            sext_q   <= sext_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            cs_q     <= cs_d;
            we_q     <= we_d;
            oe_q     <= oe_d;
            d_addr_q <= d_addr_d;
            d_in_q   <= d_in_d;
        end
    end

    assign rdata  = rdata_q;
    assign done   = done_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign cs_ram = cs_q;
    assign we     = we_q;
    assign oe     = oe_q;
    assign d_addr = d_addr_q;
    assign d_in   = d_in_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    logic        clk, rst_n, req, is_store, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, d_addr, d_in, d_out;
    logic        done, err, busy, cs_ram, we, oe;

    int          errors = 0;
    int          checks = 0;

    // memory model (DUT side) and reference byte image
    logic [7:0]  mem     [0:255];
    logic [7:0]  ref_mem [0:255];
    logic        bd_en;
    logic [7:0]  bd_addr, bd_data;
    logic [31:0] exp_rdata;

    load_store_unit #(.instruction_width(32), .ram_depth(256)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .is_store(is_store), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata),
        .done(done), .err(err), .busy(busy), .cs_ram(cs_ram), .we(we), .oe(oe),
        .d_addr(d_addr), .d_in(d_in), .d_out(d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign d_out = {mem[{d_addr[7:2], 2'd3}], mem[{d_addr[7:2], 2'd2}],
                    mem[{d_addr[7:2], 2'd1}], mem[{d_addr[7:2], 2'd0}]};

    always @(posedge clk) begin
        if (bd_en) begin
            mem[bd_addr] <= bd_data;
        end else if (cs_ram && we) begin
            for (int i = 0; i < 4; i++) mem[{d_addr[7:2], 2'(i)}] <= d_in[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    // One access, with expectations computed from byte-level semantics.
    task automatic access(input string tag, input logic st, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] wd);
        logic        bad;
        int          nb, lat, cyc, n_oe, n_we, n_cs;
        logic        got;
        logic [31:0] v;
        bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
           || (a >= 32'd256);
        nb  = 1 << sz;
        lat = bad ? 1 : ((!st || sz == 2'd2) ? 2 : 3);
        if (!bad) begin
            if (st) begin
                for (int i = 0; i < nb; i++) ref_mem[a+i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
                if (sx && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                exp_rdata = v;
            end
        end
        @(negedge clk);
        is_store = st; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
        cyc = 0; n_oe = 0; n_we = 0; n_cs = 0; got = 1'b0;
        while (!got && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                got = 1'b1;
            end else begin
                if (cs_ram) n_cs++;
                if (oe) n_oe++;
                if (we) n_we++;
            end
        end
        req = 1'b0;
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_lat"}, 32'(cyc), 32'(lat));
        check({tag, "_err"}, 32'(err), 32'(bad));
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_oecyc"}, 32'(n_oe), (bad || (st && sz == 2'd2)) ? 32'd0 : 32'd1);
        check({tag, "_wecyc"}, 32'(n_we), (!bad && st) ? 32'd1 : 32'd0);
        check({tag, "_cscyc"}, 32'(n_cs), bad ? 32'd0 : ((st && sz != 2'd2) ? 32'd2 : 32'd1));
        @(posedge clk); #1;
        check({tag, "_pulse"}, {busy, done}, 32'd0);
    endtask

    initial begin
        int d1, d2, cyc, n_we, n_done, n_bad, sz, a;
        req = 1'b0; is_store = 1'b0; size = 2'd0; sign_ext = 1'b0;
        addr = 32'd0; wdata = 32'd0; bd_en = 1'b0; bd_addr = 8'd0; bd_data = 8'd0;
        exp_rdata = 32'd0;
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        ref_mem[16] = 8'hBB; ref_mem[17] = 8'hAA; ref_mem[18] = 8'h99; ref_mem[19] = 8'h88;
        #1;
        check("rst_outs", {rdata, done, err, busy, cs_ram, we, oe}, 32'd0);
        check("rst_dbus", d_addr | d_in, 32'd0);
        // preload memory through the backdoor while the DUT is in reset
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); bd_en = 1'b1; bd_addr = 8'(i); bd_data = ref_mem[i];
        end
        @(negedge clk); bd_en = 1'b0;
        rst_n = 1'b1;

        access("ld_w10", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        check("ld_w10_lit", rdata, 32'h8899AABB);
        access("ld_b12s", 1'b0, 2'd0, 1'b1, 32'h12, 32'd0);
        check("ld_b12s_lit", rdata, 32'hFFFFFF99);
        access("ld_b12z", 1'b0, 2'd0, 1'b0, 32'h12, 32'd0);
        check("ld_b12z_lit", rdata, 32'h00000099);
        access("ld_h12s", 1'b0, 2'd1, 1'b1, 32'h12, 32'd0);
        check("ld_h12s_lit", rdata, 32'hFFFF8899);
        access("st_b11", 1'b1, 2'd0, 1'b0, 32'h11, 32'h12345655);
        check("st_b11_mem", mem_word(16), 32'h889955BB);
        access("er_h11", 1'b0, 2'd1, 1'b0, 32'h11, 32'd0);
        access("er_sz3", 1'b0, 2'd3, 1'b0, 32'h10, 32'd0);
        access("er_w100", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        check("er_rdata_lit", rdata, 32'hFFFF8899);

        // reset in the middle of the read half of a byte store
        @(negedge clk);
        is_store = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h77; req = 1'b1;
        @(posedge clk); #1;
        check("rmw_rd_cs", {cs_ram, oe, we}, 32'b110);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_ctl", {cs_ram, oe, we, busy, done}, 32'd0);
        check("rstmid_dbus", d_addr | d_in, 32'd0);
        req = 1'b0; exp_rdata = 32'd0;
        n_done = 0; n_we = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) n_done++;
            if (we) n_we++;
        end
        @(negedge clk); rst_n = 1'b1;
        check("rstmid_nodone", 32'(n_done), 32'd0);
        check("rstmid_nowe", 32'(n_we), 32'd0);
        check("rstmid_mem", mem_word(16), 32'h889955BB);
        check("rstmid_rdata", rdata, 32'd0);

        // req held high across two word stores
        @(negedge clk);
        is_store = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 32'h20; wdata = 32'hAAAA5555; req = 1'b1;
        cyc = 0; d1 = -1; d2 = -1; n_we = 0;
        while (d2 < 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (we) n_we++;
            if (done) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    wdata = 32'h0F0F0F0F;
                end else begin
                    d2 = cyc;
                end
            end
        end
        req = 1'b0;
        check("b2b_first", 32'(d1), 32'd2);
        check("b2b_gap", 32'(d2 - d1), 32'd3);
        check("b2b_we", 32'(n_we), 32'd2);
        check("b2b_mem", mem_word(32), 32'h0F0F0F0F);
        for (int i = 0; i < 4; i++) ref_mem[32+i] = 8'h0F;
        @(posedge clk); #1;

        // randomized accesses against the byte-level reference
        for (int k = 0; k < 50; k++) begin
            sz = $urandom_range(0, 3);
            a  = $urandom_range(0, 263);
            if ($urandom_range(0, 3) != 0 && sz < 3) a = a & ~((1 << sz) - 1);
            access("rnd", 1'($urandom_range(0, 1)), 2'(sz), 1'($urandom_range(0, 1)),
                   32'(a), $urandom);
        end
        n_bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n_bad++;
        check("final_mem", 32'(n_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
